// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing definitions for the sync generator and the renderers.
//   - Default 640x480@60 Hz horizontal/vertical timing constants.
//   - Derived H_TOTAL / V_TOTAL.
//   - coord_t: 10-bit unsigned pixel/line coordinate.
//   - in_window(): inclusive unsigned range test used for sync decode.
// Renderers use H_DISPLAY / V_DISPLAY for their region bounds.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // True when lo <= v <= hi, unsigned on the coordinate width.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// ---------------------------------------------------------------------------
// pixel_tick_div
// Divides the system clock down to a one-clock pixel tick.
// Parameters:
//   CLK_DIV   system clocks per pixel (>= 2)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick_next  combinational: the next clk edge is a pixel tick edge
//   p_tick     registered one-clk pulse, high in the clk after that edge
// The divider counts 0..CLK_DIV-1; p_tick is set on the edge that leaves
// CLK_DIV-1, so the first pulse appears CLK_DIV clks after reset release.
// ---------------------------------------------------------------------------
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_next,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("pixel_tick_div: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0] div_reg;
    logic             p_tick_reg;

    assign tick_next = (div_reg == DIV_MAX);
    assign p_tick    = p_tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg    <= '0;
            p_tick_reg <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two dividers work.
            div_reg    <= tick_next ? '0 : div_reg + DIV_W'(1);
            p_tick_reg <= tick_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// VGA timing generator (default 640x480@60 Hz from a 100 MHz clock).
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   p_tick      one-clk pulse per pixel period
//   x           horizontal count 0..H_TOTAL-1
//   y           vertical count 0..V_TOTAL-1
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   video_on    high while x < H_DISPLAY and y < V_DISPLAY
//   frame_tick  (only with VGA_SYNC_FRAME_TICK_EN defined) one-clk pulse
//               coincident with the p_tick on which (x,y) wraps to (0,0)
// Optional feature macro: VGA_SYNC_FRAME_TICK_EN. Without it the frame_tick
// port does not exist and consumers detect y == V_DISPLAY themselves.
// Sync and video_on are registered from the next-state x/y so they change
// on exactly the same edge as the coordinates.
// ---------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST    = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS     = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS     = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_LO = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SYNC_HI = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t V_SYNC_LO = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SYNC_HI = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    generate
        if (H_TOT > 1024) begin : g_bad_h
            $error("vga_sync_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOT > 1024) begin : g_bad_v
            $error("vga_sync_gen: V_TOTAL exceeds 1024");
        end
    endgenerate

    // -----------------------------------------------------------------
    // Pixel tick
    // -----------------------------------------------------------------
    logic tick_next;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_next (tick_next),
        .p_tick    (p_tick)
    );

    // -----------------------------------------------------------------
    // Position counters
    // -----------------------------------------------------------------
    coord_t x_reg, x_next;
    coord_t y_reg, y_next;
    logic   hsync_reg, vsync_reg, video_on_reg;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (tick_next) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + coord_t'(1);
            end else begin
                x_next = x_reg + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            hsync_reg    <= 1'b1;
            vsync_reg    <= 1'b1;
            video_on_reg <= 1'b1;
        end else begin
            x_reg        <= x_next;
            y_reg        <= y_next;
            // Decoded from next-state position: zero skew against x/y.
            hsync_reg    <= ~in_window(x_next, H_SYNC_LO, H_SYNC_HI);
            vsync_reg    <= ~in_window(y_next, V_SYNC_LO, V_SYNC_HI);
            video_on_reg <= (x_next < H_VIS) && (y_next < V_VIS);
        end
    end

    assign x        = x_reg;
    assign y        = y_reg;
    assign hsync    = hsync_reg;
    assign vsync    = vsync_reg;
    assign video_on = video_on_reg;

    // -----------------------------------------------------------------
    // Frame pulse
    // -----------------------------------------------------------------
`ifdef VGA_SYNC_FRAME_TICK_EN
    logic frame_tick_reg;

    // Only a real wrap from the last position sets it, never reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= tick_next && (x_reg == H_LAST) && (y_reg == V_LAST);
        end
    end

    assign frame_tick = frame_tick_reg;
`else
    // No frame pulse: downstream logic watches y reaching V_DISPLAY.
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
// Two instances share clk/rst_n: the default 640x480 timing and a tiny
// 12x7 timing with CLK_DIV=2 so whole frames fit in a short run. Every
// output is compared on each falling edge against a reference computed
// directly from the number of clocks since reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       frame_tick;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       d_p_tick, d_hsync, d_vsync, d_video_on;
    logic [9:0] d_x, d_y;
    logic       s_p_tick, s_hsync, s_vsync, s_video_on;
    logic [9:0] s_x, s_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
    logic       d_frame_tick, s_frame_tick;
`endif

    int checks = 0;
    int errors = 0;
    int clk_n  = 0;   // clk edges seen since reset release

    vga_sync_gen dut_d (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (d_p_tick),
        .x          (d_x),
        .y          (d_y),
        .hsync      (d_hsync),
        .vsync      (d_vsync),
        .video_on   (d_video_on)
`ifdef VGA_SYNC_FRAME_TICK_EN
        ,
        .frame_tick (d_frame_tick)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV   (2),
        .H_DISPLAY (8),
        .H_FRONT   (1),
        .H_SYNC    (2),
        .H_BACK    (1),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (s_p_tick),
        .x          (s_x),
        .y          (s_y),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .video_on   (s_video_on)
`ifdef VGA_SYNC_FRAME_TICK_EN
        ,
        .frame_tick (s_frame_tick)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_n <= 0;
        else        clk_n <= clk_n + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: after n clocks there have been n/div pixel ticks; the
    // position is the tick count modulo the frame size, laid out row-major.
    function automatic exp_t model(input int n, input int div,
                                   input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb);
        exp_t e;
        int ht, vt, ticks, pos, px, py;
        ht    = hd + hf + hs + hb;
        vt    = vd + vf + vs + vb;
        ticks = n / div;
        pos   = ticks % (ht * vt);
        px    = pos % ht;
        py    = pos / ht;
        e.p_tick     = (n >= div) && (n % div == 0);
        e.x          = 10'(px);
        e.y          = 10'(py);
        e.hsync      = !((px >= hd + hf) && (px < hd + hf + hs));
        e.vsync      = !((py >= vd + vf) && (py < vd + vf + vs));
        e.video_on   = (px < hd) && (py < vd);
        e.frame_tick = e.p_tick && (pos == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t ed, es;
        ed = model(clk_n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        es = model(clk_n, 2, 8, 1, 2, 1, 4, 1, 1, 1);
        check("d_p_tick",   int'(d_p_tick),   int'(ed.p_tick));
        check("d_x",        int'(d_x),        int'(ed.x));
        check("d_y",        int'(d_y),        int'(ed.y));
        check("d_hsync",    int'(d_hsync),    int'(ed.hsync));
        check("d_vsync",    int'(d_vsync),    int'(ed.vsync));
        check("d_video_on", int'(d_video_on), int'(ed.video_on));
        check("s_p_tick",   int'(s_p_tick),   int'(es.p_tick));
        check("s_x",        int'(s_x),        int'(es.x));
        check("s_y",        int'(s_y),        int'(es.y));
        check("s_hsync",    int'(s_hsync),    int'(es.hsync));
        check("s_vsync",    int'(s_vsync),    int'(es.vsync));
        check("s_video_on", int'(s_video_on), int'(es.video_on));
`ifdef VGA_SYNC_FRAME_TICK_EN
        check("d_frame_tick", int'(d_frame_tick), int'(ed.frame_tick));
        check("s_frame_tick", int'(s_frame_tick), int'(es.frame_tick));
`endif
    end

    // Asynchronous clear: outputs must already be at reset values
    // shortly after rst_n falls, with no clock edge in between.
    task automatic check_async_clear(input string where);
        check({where, "_d_p_tick"},   int'(d_p_tick),   0);
        check({where, "_d_x"},        int'(d_x),        0);
        check({where, "_d_y"},        int'(d_y),        0);
        check({where, "_d_hsync"},    int'(d_hsync),    1);
        check({where, "_d_vsync"},    int'(d_vsync),    1);
        check({where, "_d_video_on"}, int'(d_video_on), 1);
        check({where, "_s_p_tick"},   int'(s_p_tick),   0);
        check({where, "_s_x"},        int'(s_x),        0);
        check({where, "_s_y"},        int'(s_y),        0);
        check({where, "_s_hsync"},    int'(s_hsync),    1);
        check({where, "_s_vsync"},    int'(s_vsync),    1);
        check({where, "_s_video_on"}, int'(s_video_on), 1);
    endtask

    task automatic run_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int len, hold;
        rst_n = 1'b0;
        run_clks(5);
        #2 rst_n = 1'b1;
        $display("txn 0: reset released, running two default lines");
        // Two default lines plus margin: covers video_on fall at 640,
        // hsync window 656..751 and the 799->0 / y 0->1 wrap.
        run_clks(2 * 800 * 4 + 100);
        $display("txn 1: default at x=%0d y=%0d, small at x=%0d y=%0d",
                 d_x, d_y, s_x, s_y);

        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(50, 3000);
            run_clks(len);
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            #1;
            check_async_clear($sformatf("async%0d", k));
            hold = $urandom_range(1, 3);
            run_clks(hold);
            #2 rst_n = 1'b1;
            $display("txn %0d: ran %0d clks, async reset held %0d clks", k + 2, len, hold);
        end

        // Long tail: many small frames after the last release.
        run_clks(1200);
        $display("txn 8: tail run done, default at x=%0d y=%0d", d_x, d_y);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing: the pixel coordinates x/y that the text, paddle and ball renderers consume, plus hsync/vsync and a video-active flag.
- Writer side of the pixel-coordinate interface. Renderers read x/y and return RGB; this block produces x/y and sync.
- Sits between the board clock and the top-level pixel mux.
- Divides the system clock down to a pixel tick. All counters advance only on that tick.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- p_tick  out  1  one-clk pulse marking each pixel period
- x  out  10  horizontal pixel count, 0..H_TOTAL-1
- y  out  10  vertical line count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while x < H_DISPLAY and y < V_DISPLAY

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Every flop clears on rst_n low with no clock required.
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - Elaboration error if H_TOTAL > 1024 or V_TOTAL > 1024.
- Reset values: divider=0, x=0, y=0, p_tick=0, hsync=1, vsync=1, video_on=1. Video_on=1 is consistent with position (0,0).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - p_tick is registered. It is high for exactly one clk when the divider value is CLK_DIV-1.
  - p_tick period is CLK_DIV clks.
  - First p_tick comes CLK_DIV clks after reset release.
- Horizontal counter: advances in the same clk that p_tick is high.
  - x == H_TOTAL-1 -> x=0, and y advances.
  - Otherwise x+1.
- Vertical counter: advances only when x wraps.
  - y == V_TOTAL-1 -> y=0.
  - Otherwise y+1.
- Frame wrap: (799,524) -> (0,0) on a single p_tick.
- Output alignment:
  - hsync, vsync and video_on are registered, computed from the next-state x/y.
  - They therefore change in the same clk edge as x/y. There is zero skew between position and sync.
- Sync windows:
  - hsync=0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync=0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- Between ticks: x, y, hsync, vsync and video_on hold their values. Outputs are glitch-free (all registered).
- Reset mid-line or mid-frame: all state returns to reset values immediately. There is no partial-line completion. The first line after release starts at x=0, y=0.
- Arithmetic:
  - All compares are unsigned on 10 bits.
  - The divider is $clog2(CLK_DIV) bits wide.
  - No overflow is possible past the wrap compares.

Optional Feature:
- Macro: VGA_SYNC_FRAME_TICK_EN.
- Defined:
  - Adds output frame_tick (1 bit, reset 0).
  - frame_tick is a registered one-clk pulse coincident with the p_tick on which (x,y) becomes (0,0) after a wrap.
  - It does not pulse on reset release.
  - Used by the game FSM to step ball/paddle once per frame.
- Undefined: port and logic are absent. The game FSM must then detect y==V_DISPLAY itself.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default H/V timing constants and derived H_TOTAL/V_TOTAL;
  - the 10-bit coordinate type;
  - H_DISPLAY/V_DISPLAY, also consumed by the renderers for region bounds.
- One natural sub-module, pixel_tick_div: divider counter plus registered p_tick, parameterised by CLK_DIV.
- The counters and sync decode stay in vga_sync_gen.

Test Plan:
- Reset then release:
  - p_tick first high 4 clks after release, then every 4 clks.
  - x=0, y=0, hsync=1, vsync=1, video_on=1 throughout.
- Run one line:
  - video_on falls on the tick where x becomes 640.
  - hsync falls at x=656 and rises at x=752.
  - x wraps 799->0 and y increments 0->1 on the same edge.
- Run to line 490:
  - vsync low exactly for y=490 and y=491, spanning 1600 pixel ticks.
  - video_on low for all of y >= 480.
- Frame wrap:
  - (799,524) -> (0,0) in one tick, video_on back to 1.
  - With VGA_SYNC_FRAME_TICK_EN, frame_tick pulses once on that edge; 420000 ticks separate consecutive pulses.
- Assert rst_n low at x=300, y=200 between clk edges:
  - Outputs clear asynchronously before the next edge.
  - After release, the sequence restarts as in the first scenario.
- Re-parameterise CLK_DIV=2, H_DISPLAY=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1:
  - H_TOTAL=12 and V_TOTAL=7.
  - hsync low at x=9..10, vsync low at y=5.
  - Full frame = 84 ticks = 168 clks.
